// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants and types for the ID-stage hazard scoreboard.
// Latency defaults are bubble counts a consumer waits behind each producer class.
package hazard_scoreboard_pkg;
  localparam int SB_REG_W    = 5;
  localparam int SB_NUM_REGS = 32;
  localparam int CNT_W       = 2;
  localparam int SB_LOAD_LAT = 1;
  localparam int SB_ALU_LAT  = 0;
  localparam int SB_PERF_W   = 16;

  localparam logic [SB_REG_W-1:0] ZERO_REG = 5'd0;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t lat_sel(input logic is_load, input int load_lat, input int alu_lat);
    return is_load ? cnt_t'(load_lat) : cnt_t'(alu_lat);
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage bus between decoder/pipeline control and the hazard scoreboard.
// master = decode/pipeline side, slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_W    = 5,
  parameter int NUM_REGS = 32,
  parameter int PERF_W   = 16
);
  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_wr_en;
  logic [REG_W-1:0]  id_rd;
  logic              id_is_load;
  logic              flush;
  logic              mem_wait;
  logic              stall;
  logic              pc_load;
  logic              IFID_Ld;
  logic              sel_signal;
  logic [NUM_REGS-1:0] busy_mask;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_rd, id_is_load,
           flush, mem_wait,
    input  stall, pc_load, IFID_Ld, sel_signal, busy_mask, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_rd, id_is_load,
           flush, mem_wait,
    output stall, pc_load, IFID_Ld, sel_signal, busy_mask, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard slot: remaining bubbles before the register's producer is forwardable.
// Hold beats load so a frozen back end neither ages nor accepts a new writer.
module sb_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hold_i,
  input  logic load_i,
  input  cnt_t load_val_i,
  output cnt_t cnt_o
);
  cnt_t cnt_q;
  cnt_t cnt_d;

  // Next count: hold, newest-writer load, or age toward zero.
  always_comb begin
    cnt_d = cnt_q;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != cnt_t'(0)) begin
      cnt_d = cnt_q - cnt_t'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= cnt_t'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register producer scoreboard: ID source lookups generate stall/bubble/hold
// controls; issuing writers arm a countdown that ages to "forwardable".
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int REG_W    = SB_REG_W,
  parameter int LOAD_LAT = SB_LOAD_LAT,
  parameter int ALU_LAT  = SB_ALU_LAT,
  parameter int PERF_W   = SB_PERF_W
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave sb_io
);
  localparam logic [REG_W-1:0]  RZERO    = REG_W'(ZERO_REG);
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  cnt_t                cnt_s [NUM_REGS];
  logic [NUM_REGS-1:0] busy_s;
  logic                haz_rs_s;
  logic                haz_rt_s;
  logic                stall_s;
  logic                issue_s;
  cnt_t                issue_val_s;
  logic [PERF_W-1:0]   stall_cycles_q;
  logic [PERF_W-1:0]   stall_cycles_d;

  assign cnt_s[0]  = cnt_t'(0);
  assign busy_s[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
    sb_entry u_entry (
      .clk        (clk),
      .rst        (rst),
      .hold_i     (sb_io.mem_wait),
      .load_i     (issue_s && (sb_io.id_rd == REG_W'(g))),
      .load_val_i (issue_val_s),
      .cnt_o      (cnt_s[g])
    );
    assign busy_s[g] = (cnt_s[g] != cnt_t'(0));
  end

  // Source lookup against pre-update counts; rs==rt naturally collapses to one hazard.
  always_comb begin
    haz_rs_s    = sb_io.id_uses_rs && (sb_io.id_rs != RZERO) && busy_s[sb_io.id_rs];
    haz_rt_s    = sb_io.id_uses_rt && (sb_io.id_rt != RZERO) && busy_s[sb_io.id_rt];
    stall_s     = (sb_io.id_valid && !sb_io.flush && (haz_rs_s || haz_rt_s)) || sb_io.mem_wait;
    issue_s     = sb_io.id_valid && !stall_s && !sb_io.flush && sb_io.id_wr_en &&
                  (sb_io.id_rd != RZERO);
    issue_val_s = lat_sel(sb_io.id_is_load, LOAD_LAT, ALU_LAT);
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_s && (stall_cycles_q != PERF_MAX)) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= {PERF_W{1'b0}};
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign sb_io.stall        = stall_s;
  assign sb_io.pc_load      = !stall_s;
  assign sb_io.IFID_Ld      = !stall_s;
  assign sb_io.sel_signal   = !(stall_s || sb_io.flush);
  assign sb_io.busy_mask    = busy_s;
  assign sb_io.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard: two instances (LOAD/ALU latency 1/0 and 2/1)
// checked each cycle against a ready-time reference model.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if if_a ();
  hazard_scoreboard_if if_b ();

  hazard_scoreboard #(.LOAD_LAT(1), .ALU_LAT(0)) dut_a (.clk(clk), .rst(rst), .sb_io(if_a));
  hazard_scoreboard #(.LOAD_LAT(2), .ALU_LAT(1)) dut_b (.clk(clk), .rst(rst), .sb_io(if_b));

  int checks = 0;
  int errors = 0;

  // Current stimulus
  logic       tv_valid, tv_urs, tv_urt, tv_wr, tv_ld, tv_fl, tv_mw;
  logic [4:0] tv_rs, tv_rt, tv_rd;

  // Reference model: a register is busy while the active-cycle clock is below its ready time.
  longint     now [2];
  longint     ready_at [2][32];
  int         lat_load [2] = '{1, 2};
  int         lat_alu  [2] = '{0, 1};
  logic [15:0] perf [2];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic m_busy(input int m, input logic [4:0] r);
    return (r != 5'd0) && (ready_at[m][r] > now[m]);
  endfunction

  function automatic logic m_stall(input int m);
    logic hz;
    hz = (tv_urs && m_busy(m, tv_rs)) || (tv_urt && m_busy(m, tv_rt));
    return (tv_valid && !tv_fl && hz) || tv_mw;
  endfunction

  function automatic logic [31:0] m_mask(input int m);
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy(m, 5'(r));
    return v;
  endfunction

  task automatic m_update(input int m, input logic st);
    if (rst) begin
      for (int r = 0; r < 32; r++) ready_at[m][r] = 0;
      perf[m] = 16'd0;
    end else begin
      if (st && perf[m] != 16'hFFFF) perf[m] = perf[m] + 16'd1;
      if (!tv_mw) begin
        if (tv_valid && !st && !tv_fl && tv_wr && tv_rd != 5'd0)
          ready_at[m][tv_rd] = now[m] + 1 + (tv_ld ? lat_load[m] : lat_alu[m]);
        now[m] = now[m] + 1;
      end
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic wr,
                        input logic [4:0] rd, input logic ld, input logic fl, input logic mw);
    tv_valid = v; tv_rs = rs; tv_rt = rt; tv_urs = urs; tv_urt = urt;
    tv_wr = wr; tv_rd = rd; tv_ld = ld; tv_fl = fl; tv_mw = mw;
    if_a.id_valid = v; if_a.id_rs = rs; if_a.id_rt = rt; if_a.id_uses_rs = urs;
    if_a.id_uses_rt = urt; if_a.id_wr_en = wr; if_a.id_rd = rd; if_a.id_is_load = ld;
    if_a.flush = fl; if_a.mem_wait = mw;
    if_b.id_valid = v; if_b.id_rs = rs; if_b.id_rt = rt; if_b.id_uses_rs = urs;
    if_b.id_uses_rt = urt; if_b.id_wr_en = wr; if_b.id_rd = rd; if_b.id_is_load = ld;
    if_b.flush = fl; if_b.mem_wait = mw;
  endtask

  task automatic check_dut(input string nm, input int m, input logic st, input logic pc,
                           input logic ifid, input logic sel, input logic [31:0] bm,
                           input logic [15:0] sc);
    logic es;
    es = m_stall(m);
    check_value({nm, "_stall"}, 32'(st), 32'(es));
    check_value({nm, "_pc_load"}, 32'(pc), 32'(!es));
    check_value({nm, "_IFID_Ld"}, 32'(ifid), 32'(!es));
    check_value({nm, "_sel_signal"}, 32'(sel), 32'(!(es || tv_fl)));
    check_value({nm, "_busy_mask"}, bm, m_mask(m));
    check_value({nm, "_stall_cycles"}, 32'(sc), 32'(perf[m]));
  endtask

  task automatic run_cycle();
    logic st0, st1;
    #1;
    check_dut("a", 0, if_a.stall, if_a.pc_load, if_a.IFID_Ld, if_a.sel_signal,
              if_a.busy_mask, if_a.stall_cycles);
    check_dut("b", 1, if_b.stall, if_b.pc_load, if_b.IFID_Ld, if_b.sel_signal,
              if_b.busy_mask, if_b.stall_cycles);
    st0 = m_stall(0);
    st1 = m_stall(1);
    @(posedge clk);
    m_update(0, st0);
    m_update(1, st1);
    @(negedge clk);
  endtask

  task automatic idle(input logic mw);
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, mw);
    run_cycle();
  endtask

  // Keep presenting an instruction until neither instance stalls on it (bounded).
  task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic wr, input logic [4:0] rd, input logic ld);
    logic any;
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, rs, rt, urs, urt, wr, rd, ld, 1'b0, 1'b0);
      any = m_stall(0) || m_stall(1);
      run_cycle();
      if (!any) break;
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      now[m] = 0;
      perf[m] = 16'd0;
      for (int r = 0; r < 32; r++) ready_at[m][r] = 0;
    end
    rst = 1'b1;
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    run_cycle();
    run_cycle();
    rst = 1'b0;
    #1;
    check_value("reset_pc_load", 32'(if_a.pc_load), 32'd1);
    check_value("reset_sel_signal", 32'(if_a.sel_signal), 32'd1);
    check_value("reset_busy_mask", if_a.busy_mask, 32'd0);
    check_value("reset_stall_cycles", 32'(if_a.stall_cycles), 32'd0);
    idle(1'b0);

    // Load-use: one bubble on A, two on B
    present(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
    present(5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
    check_value("a_load_use_stall_cycles", 32'(if_a.stall_cycles), 32'd1);
    check_value("b_load_use_stall_cycles", 32'(if_b.stall_cycles), 32'd2);

    // ALU producer and r0 producer/consumer
    present(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    set_in(1'b1, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0);
    #1 check_value("a_alu_no_stall", 32'(if_a.stall), 32'd0);
    present(5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0);
    present(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1);
    set_in(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1 check_value("a_r0_no_stall", 32'(if_a.stall), 32'd0);
    run_cycle();

    // Freeze during a load shadow, then the consumer still waits
    present(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
    for (int k = 0; k < 3; k++) idle(1'b1);
    check_value("a_busy8_after_wait", 32'(if_a.busy_mask[8]), 32'd1);
    present(5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);

    // Flush over a hazard: bubble only, no issue
    present(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
    set_in(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11, 1'b0, 1'b1, 1'b0);
    #1 check_value("a_flush_sel", 32'(if_a.sel_signal), 32'd0);
    run_cycle();
    idle(1'b0);
    idle(1'b0);

    // Reset in the middle of B's two-bubble stall
    present(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);
    set_in(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    #1;
    check_value("b_post_rst_stall", 32'(if_b.stall), 32'd0);
    check_value("b_post_rst_busy", if_b.busy_mask, 32'd0);
    run_cycle();

    // Randomized traffic over a small register window
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      set_in($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), $urandom_range(0, 9) < 7,
             5'($urandom_range(0, 7)), $urandom_range(0, 9) < 4,
             $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 1);
      run_cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side counterpart of the load-use stall check: a per-register scoreboard that records each destination register as instructions leave ID and ages it down to "forwardable".
- ID-stage source lookups against the scoreboard generate stall, bubble and hold controls for PC, IF/ID and the ID/EX control mux.
- Generalises the single-cycle load-use check to configurable producer latencies, with memory-wait freeze and flush handling.
- Sits beside the decoder in ID and drives pc_load, IFID_Ld and sel_signal.

Parameters:
- NUM_REGS, 32, architectural registers; register 0 is hardwired zero.
- REG_W, 5, register index width.
- LOAD_LAT, 1, bubbles a load consumer needs (0..3).
- ALU_LAT, 0, bubbles an ALU consumer needs (0..3).
- PERF_W, 16, stall performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  valid instruction in ID.
- id_rs  in  REG_W  source register 1.
- id_rt  in  REG_W  source register 2.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_wr_en  in  1  instruction writes a register.
- id_rd  in  REG_W  destination register (already muxed rt/rd/31).
- id_is_load  in  1  destination is produced by a memory read.
- flush  in  1  kill the ID instruction (taken branch/jump).
- mem_wait  in  1  back end frozen (multi-cycle memory).
- stall  out  1  hazard present this cycle.
- pc_load  out  1  0 = hold PC.
- IFID_Ld  out  1  0 = hold IF/ID.
- sel_signal  out  1  0 = zero ID/EX controls (bubble).
- busy_mask  out  NUM_REGS  bit r = cnt[r] != 0.
- stall_cycles  out  PERF_W  saturating count of stall cycles.

Behaviour:
- State: cnt[r], CNT_W=2 bits per register, r = 1..NUM_REGS-1. cnt[0] is constant 0.
- Hazard, combinational:
  - haz_rs = id_uses_rs && id_rs!=0 && cnt[id_rs]!=0.
  - haz_rt = id_uses_rt && id_rt!=0 && cnt[id_rt]!=0.
  - stall = id_valid && !flush && (haz_rs || haz_rt) || mem_wait.
- Outputs: pc_load = IFID_Ld = !stall. sel_signal = !(stall || flush).
- Issue condition: issue = id_valid && !stall && !flush && id_wr_en && id_rd!=0.
- Per-cycle update, in priority order:
  1. rst: all cnt = 0, stall_cycles = 0.
  2. mem_wait: all cnt hold (no ageing, no issue).
  3. Otherwise every nonzero cnt decrements by 1. If issue, cnt[id_rd] = (id_is_load ? LOAD_LAT : ALU_LAT), overriding any in-flight value for that register (newest writer wins).
- Latency:
  - A consumer directly behind a load stalls exactly LOAD_LAT cycles.
  - A consumer behind an ALU op with ALU_LAT=0 never stalls.
  - Lookup uses the pre-update cnt. An issue this cycle affects the next cycle's lookup.
- stall_cycles increments when stall=1 and not rst, saturating at all-ones.
- Reset outputs: stall=0, pc_load=1, IFID_Ld=1, sel_signal=1, busy_mask=0, stall_cycles=0. stall still follows mem_wait combinationally after reset releases.
- Boundaries:
  - Register 0 never tracked or matched.
  - flush with a hazard: no stall, bubble inserted, no issue.
  - rs==rt with both used: a single hazard.
  - A source equal to id_rd of the same instruction does not self-block.
  - rst mid-stall clears the scoreboard; the next cycle is stall-free unless mem_wait.
  - LOAD_LAT=0 makes the block pass-through: only mem_wait stalls.

Decomposition:
- Shared pipeline package: REG_W, NUM_REGS, CNT_W, the zero-register constant, latency defaults.
- One sub-module, sb_entry: a 2-bit saturating down-counter with load, hold and decrement, instantiated NUM_REGS-1 times.
- Hazard compare and perf counter stay in the top module.

Test Plan:
- rst held 2 cycles, then released with all inputs 0 -> pc_load=IFID_Ld=sel_signal=1, busy_mask=0, stall_cycles=0.
- lw rd=8 issued at cycle t, then add rs=8 at t+1 -> stall=1 and sel_signal=0 at t+1 only; issued at t+2; stall_cycles=1.
- add rd=9 at t, then sub rt=9 at t+1 (ALU_LAT=0) -> no stall. Also lw rd=0, then a use of r0 -> no stall.
- lw rd=8, then mem_wait=1 for 3 cycles, then a consumer of r8 -> stall during the wait; busy_mask[8] stays 1; after release the consumer still stalls 1 cycle.
- lw rd=8, then a consumer of r8 with flush=1 in the same cycle -> stall=0, sel_signal=0, nothing issued.
- LOAD_LAT=2: lw rd=5 followed by a consumer -> 2 stall cycles. rst asserted after the first of these -> next cycle stall=0, busy_mask=0.
